// File: rtl/tap_sequencer_pkg.sv
// Shared equalizer definitions: sequencer state encoding and default sizing.
package tap_sequencer_pkg;

   localparam int DATA_W_DEFAULT = 16;
   localparam int TAPS_DEFAULT   = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/sample_ring.sv
// Circular sample history: one write port, one registered read port with write-through
// so a sample written on an edge is visible on the read port after that same edge.
module sample_ring #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [$clog2(TAPS)-1:0] wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   input  logic                    rd_zero,
   input  logic [$clog2(TAPS)-1:0] rd_addr,
   output logic [DATA_W-1:0]       rd_data
);

   logic [DATA_W-1:0] mem [TAPS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         if (rd_zero)
            rd_data <= '0;
         else if (wr_en && (wr_addr == rd_addr))
            rd_data <= wr_data;
         else
            rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/tap_sequencer.sv
// FIR tap sequencer: steps TAPS phases per accepted sample, outputs registered one edge after the step;
// one-deep hold absorbs a sample mid-frame, sample_ready drops while it is full. TAP_SEQUENCER_OVERRUN_EN adds overrun_count.
module tap_sequencer
   import tap_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int TAPS   = TAPS_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_enable,
   input  logic [DATA_W-1:0]       sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic [DATA_W-1:0]       input_mux,
   output logic [$clog2(TAPS)-1:0] tap_index,
   output logic                    phase_0,
   output logic                    phase_63
`ifdef TAP_SEQUENCER_OVERRUN_EN
   ,
   output logic [7:0]              overrun_count
`endif
);

   localparam int             PW   = $clog2(TAPS);
   localparam logic [PW-1:0]  LAST = PW'(TAPS - 1);

   seq_state_t        state, state_n;
   logic [PW-1:0]     wp, wp_n;
   logic [PW-1:0]     phase, phase_n;
   logic [DATA_W-1:0] hold;
   logic              hold_full, hold_full_n, hold_load;
   logic              accept;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              run_n, p0_n, p63_n;
   logic [PW-1:0]     tap_n, rd_addr;

   assign sample_ready = !hold_full;
   assign accept       = clk_enable && sample_valid && !hold_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         wp        <= '0;
         phase     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tap_index <= '0;
         phase_0   <= 1'b0;
         phase_63  <= 1'b0;
      end else if (clk_enable) begin
         state     <= state_n;
         wp        <= wp_n;
         phase     <= phase_n;
         hold_full <= hold_full_n;
         if (hold_load) hold <= sample_in;
         tap_index <= tap_n;
         phase_0   <= p0_n;
         phase_63  <= p63_n;
      end
   end

   always_comb begin
      state_n     = state;
      wp_n        = wp;
      phase_n     = phase;
      hold_full_n = hold_full;
      hold_load   = 1'b0;
      wr_en       = 1'b0;
      wr_data     = sample_in;
      if (clk_enable) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  wr_en   = 1'b1;
                  wp_n    = wp + PW'(1);
                  phase_n = '0;
                  state_n = ST_RUN;
               end
            end
            ST_RUN: begin
               // Frame boundary: a held sample wins; otherwise a fresh offer starts the next frame directly.
               if (phase == LAST) begin
                  phase_n = '0;
                  if (hold_full) begin
                     wr_en       = 1'b1;
                     wr_data     = hold;
                     wp_n        = wp + PW'(1);
                     hold_full_n = 1'b0;
                  end else if (accept) begin
                     wr_en = 1'b1;
                     wp_n  = wp + PW'(1);
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  phase_n = phase + PW'(1);
                  if (accept) begin
                     hold_load   = 1'b1;
                     hold_full_n = 1'b1;
                  end
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      run_n   = (state_n == ST_RUN);
      tap_n   = run_n ? phase_n : '0;
      p0_n    = run_n && (phase_n == '0);
      p63_n   = run_n && (phase_n == LAST);
      rd_addr = wp_n - phase_n;
   end

   sample_ring #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) u_ring (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wp_n),
      .wr_data (wr_data),
      .rd_en   (clk_enable),
      .rd_zero (!run_n),
      .rd_addr (rd_addr),
      .rd_data (input_mux)
   );

`ifdef TAP_SEQUENCER_OVERRUN_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         overrun_count <= 8'd0;
      else if (clk_enable && sample_valid && hold_full && (overrun_count != 8'hFF))
         overrun_count <= overrun_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_tap_sequencer.sv
// Bench for tap_sequencer: vector table, directed frame corner cases, random traffic vs a queue-based model.
module tb_tap_sequencer;

   localparam int DW   = 16;
   localparam int TAPS = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clk_enable = 1'b0;
   logic          sample_valid = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic          sample_ready;
   logic [DW-1:0] input_mux;
   logic [5:0]    tap_index;
   logic          phase_0, phase_63;
`ifdef TAP_SEQUENCER_OVERRUN_EN
   logic [7:0]    overrun_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tap_sequencer #(.DATA_W(DW), .TAPS(TAPS)) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_enable   (clk_enable),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .input_mux    (input_mux),
      .tap_index    (tap_index),
      .phase_0      (phase_0),
      .phase_63     (phase_63)
`ifdef TAP_SEQUENCER_OVERRUN_EN
      ,
      .overrun_count(overrun_count)
`endif
   );

   // Reference model: history queue (newest first), frame position and a pending-sample slot.
   logic [DW-1:0] m_hist[$];
   bit            m_run;
   int            m_phase;
   bit            m_pend;
   logic [DW-1:0] m_pend_val;
   int            m_ovr;

   function automatic void model_reset();
      m_hist.delete();
      for (int i = 0; i < TAPS; i++) m_hist.push_back('0);
      m_run = 0; m_phase = 0; m_pend = 0; m_pend_val = '0; m_ovr = 0;
   endfunction

   function automatic void model_push(logic [DW-1:0] d);
      m_hist.push_front(d);
      void'(m_hist.pop_back());
   endfunction

   function automatic void model_edge(logic en, logic v, logic [DW-1:0] d);
      bit take;
      if (!en) return;
      take = v && !m_pend;
      if (v && m_pend && m_ovr < 255) m_ovr++;
      if (!m_run) begin
         if (take) begin model_push(d); m_run = 1; m_phase = 0; end
      end else if (m_phase == TAPS - 1) begin
         m_phase = 0;
         if (m_pend) begin model_push(m_pend_val); m_pend = 0; end
         else if (take) model_push(d);
         else m_run = 0;
      end else begin
         m_phase++;
         if (take) begin m_pend = 1; m_pend_val = d; end
      end
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("m_ready", 32'(sample_ready), 32'(!m_pend));
      chk("m_mux",   32'(input_mux),    m_run ? 32'(m_hist[m_phase]) : 32'd0);
      chk("m_tap",   32'(tap_index),    m_run ? 32'(m_phase) : 32'd0);
      chk("m_p0",    32'(phase_0),      32'(m_run && m_phase == 0));
      chk("m_p63",   32'(phase_63),     32'(m_run && m_phase == TAPS - 1));
`ifdef TAP_SEQUENCER_OVERRUN_EN
      chk("m_ovr",   32'(overrun_count), 32'(m_ovr));
`endif
   endtask

   task automatic tick(logic en, logic v, logic [DW-1:0] d);
      clk_enable = en; sample_valid = v; sample_in = d;
      if (rst) model_edge(en, v, d);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && m_run; i++) tick(1'b1, 1'b0, '0);
      chk("drain_idle", 32'(m_run), 32'd0);
   endtask

   typedef struct {
      logic          en, v;
      logic [DW-1:0] d;
      logic          p0, p63;
      logic [5:0]    tap;
      logic [DW-1:0] mux;
      logic          rdy;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int drops;
      logic [DW-1:0] last_acc;

      model_reset();
      #2 rst = 1'b0;
      #2;
      chk("rst_ready", 32'(sample_ready), 32'd1);
      chk("rst_mux",   32'(input_mux), 32'd0);
      chk("rst_tap",   32'(tap_index), 32'd0);
      chk("rst_p0",    32'(phase_0), 32'd0);
      chk("rst_p63",   32'(phase_63), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single sample frame: opening cycles from the table, including frozen cycles.
      tbl[0] = '{1'b1, 1'b1, 16'h4000, 1'b1, 1'b0, 6'd0, 16'h4000, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd1, 16'h0000, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 6'd1, 16'h0000, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd2, 16'h0000, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd2, 16'h0000, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd3, 16'h0000, 1'b1};
      for (int i = 0; i < 6; i++) begin
         tick(tbl[i].en, tbl[i].v, tbl[i].d);
         chk("tbl_p0",  32'(phase_0),      32'(tbl[i].p0));
         chk("tbl_p63", 32'(phase_63),     32'(tbl[i].p63));
         chk("tbl_tap", 32'(tap_index),    32'(tbl[i].tap));
         chk("tbl_mux", 32'(input_mux),    32'(tbl[i].mux));
         chk("tbl_rdy", 32'(sample_ready), 32'(tbl[i].rdy));
      end
      for (int p = 4; p < TAPS; p++) begin
         tick(1'b1, 1'b0, '0);
         chk("single_mux0", 32'(input_mux), 32'd0);
      end
      chk("single_tap63", 32'(tap_index), 32'd63);
      chk("single_p63",   32'(phase_63), 32'd1);
      tick(1'b1, 1'b0, '0);
      chk("single_idle_tap", 32'(tap_index), 32'd0);
      chk("single_idle_p63", 32'(phase_63), 32'd0);

      // Ordering across frames.
      tick(1'b1, 1'b1, 16'h0001);
      drain();
      tick(1'b1, 1'b1, 16'h0002);
      chk("order_ph0", 32'(input_mux), 32'h0002);
      tick(1'b1, 1'b0, '0);
      chk("order_ph1", 32'(input_mux), 32'h0001);
      drain();

      // Back-to-back: offer at phase 10, no gap after phase 63.
      tick(1'b1, 1'b1, 16'hAAAA);
      for (int p = 0; p < 10; p++) tick(1'b1, 1'b0, '0);
      chk("b2b_at10", 32'(tap_index), 32'd10);
      tick(1'b1, 1'b1, 16'hBBBB);
      chk("b2b_ready0", 32'(sample_ready), 32'd0);
      for (int p = 12; p < TAPS; p++) begin
         tick(1'b1, 1'b0, '0);
         chk("b2b_ready_held", 32'(sample_ready), 32'd0);
      end
      chk("b2b_p63", 32'(phase_63), 32'd1);
      tick(1'b1, 1'b0, '0);
      chk("b2b_p0",    32'(phase_0), 32'd1);
      chk("b2b_mux",   32'(input_mux), 32'hBBBB);
      chk("b2b_ready", 32'(sample_ready), 32'd1);
      tick(1'b1, 1'b0, '0);
      chk("b2b_prev", 32'(input_mux), 32'hAAAA);
      drain();

      // Direct start: offer exactly at phase 63 with the hold empty.
      tick(1'b1, 1'b1, 16'hC0C0);
      for (int p = 1; p < TAPS; p++) tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 16'hD0D0);
      chk("direct_p0",    32'(phase_0), 32'd1);
      chk("direct_mux",   32'(input_mux), 32'hD0D0);
      chk("direct_ready", 32'(sample_ready), 32'd1);
      tick(1'b1, 1'b0, '0);
      chk("direct_prev", 32'(input_mux), 32'hC0C0);
      drain();

      // clk_enable every other cycle: frame occupies 128 clocks.
      tick(1'b1, 1'b1, 16'h5555);
      cnt = 1;
      for (int i = 0; i < 400; i++) begin
         tick(1'(i % 2 == 1), 1'b0, '0);
         if (phase_0 || tap_index != 0) cnt++;
         else break;
      end
      chk("half_rate_len", 32'(cnt), 32'd128);

      // Reset mid-frame at phase 30.
      tick(1'b1, 1'b1, 16'h7777);
      for (int p = 0; p < 30; p++) tick(1'b1, 1'b0, '0);
      chk("rst30_tap", 32'(tap_index), 32'd30);
      rst = 1'b0;
      #1;
      chk("rst30_mux",   32'(input_mux), 32'd0);
      chk("rst30_tap0",  32'(tap_index), 32'd0);
      chk("rst30_ready", 32'(sample_ready), 32'd1);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, '0);
         chk("rst30_nopulse", 32'({phase_0, phase_63}), 32'd0);
      end
      rst = 1'b1;
      tick(1'b1, 1'b1, 16'h1357);
      chk("rst30_new", 32'(input_mux), 32'h1357);
      for (int p = 1; p < TAPS; p++) begin
         tick(1'b1, 1'b0, '0);
         chk("rst30_zero_hist", 32'(input_mux), 32'd0);
      end
      drain();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++)
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), 16'($urandom));
      drain();

`ifdef TAP_SEQUENCER_OVERRUN_EN
      drops = 0;
      last_acc = '0;
      for (int i = 0; i < 3000 && drops < 300; i++) begin
         if (!sample_ready) begin
            drops++;
            tick(1'b1, 1'b1, 16'hDEAD ^ 16'(i));
         end else begin
            last_acc = 16'(i + 1);
            tick(1'b1, 1'b1, last_acc);
         end
      end
      chk("ovr_drops", 32'(drops), 32'd300);
      chk("ovr_sat", 32'(overrun_count), 32'd255);
      for (int i = 0; i < 100 && !phase_0; i++) tick(1'b1, 1'b0, '0);
      chk("ovr_hold_kept", 32'(input_mux), 32'(last_acc));
      drain();
`else
      drops = 0;
      last_acc = '0;
      if (drops != 0) $display("drops %0d %0h", drops, last_acc);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
